gb_cart_bus_sequencer: RTL and testbench

//  Synthesizable, parametrised Game Boy cartridge-bus master for on-board self-test and camera bring-up.

---
 rtl/gb_seq_pkg.sv | 47 ++++
 rtl/gb_seq_cmd_fifo.sv | 69 ++++++
 rtl/gb_cart_bus_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_gb_cart_bus_sequencer.sv | 517 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_seq_pkg.sv
// Shared types and constants for the Game Boy cart-bus sequencer.
// Op encoding, FSM states, tick indices and idle pin levels.
package gb_seq_pkg;

  localparam logic [1:0] OP_WR_REG = 2'd0;
  localparam logic [1:0] OP_WR_RAM = 2'd1;
  localparam logic [1:0] OP_RD_RAM = 2'd2;
  localparam logic [1:0] OP_RD_ROM = 2'd3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CYCLE = 1'b1;

  localparam logic [2:0] T_BEG  = 3'd0;
  localparam logic [2:0] T_ADDR = 3'd1;
  localparam logic [2:0] T_SEL  = 3'd2;
  localparam logic [2:0] T_WR   = 3'd4;
  localparam logic [2:0] T_END  = 3'd7;

  localparam logic [15:0] IDLE_A   = 16'h0000;
  localparam logic [7:0]  IDLE_D   = 8'h00;
  localparam logic        IDLE_OE  = 1'b0;
  localparam logic        IDLE_NCS = 1'b1;
  localparam logic        IDLE_NRD = 1'b0;
  localparam logic        IDLE_NWR = 1'b1;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [7:0]  data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  function automatic logic is_read(
    input logic [1:0] op
  );
    return op[1];
  endfunction

  function automatic logic is_ram(
    input logic [1:0] op
  );
    return (op == OP_WR_RAM) ||
           (op == OP_RD_RAM);
  endfunction

endpackage

// File: rtl/gb_seq_cmd_fifo.sv
// Command queue for the cart-bus sequencer.
// Power-of-two depth, wrapping pointers, count one bit wider.
module gb_seq_cmd_fifo
  import gb_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_W
) (
  input  logic                     sys_clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // storage write; contents need no reset
  always_ff @(posedge sys_clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // occupancy tracks push/pop balance
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gb_cart_bus_sequencer.sv
// Game Boy cart-bus master: replays queued commands as 8-tick bus cycles.
// Optional GB_SEQ_CART_CLK_EN: free-running PHI clock with T0 aligned to its rise.
module gb_cart_bus_sequencer
  import gb_seq_pkg::*;
#(
  parameter int TICK_CYCLES     = 13,
  parameter int FIFO_DEPTH      = 4,
  parameter int RAM_SAMPLE_TICK = 5,
  parameter int ROM_SAMPLE_TICK = 4
) (
  input  logic        sys_clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        busy,
  output logic        cart_clk,
  output logic [15:0] cart_a,
  output logic [7:0]  cart_d_out,
  output logic        cart_d_oe,
  input  logic [7:0]  cart_d_in,
  output logic        cart_nCS,
  output logic        cart_nRD,
  output logic        cart_nWR
);

  localparam int CW  = $clog2(TICK_CYCLES);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  logic [0:0]       state;
  logic [2:0]       tick;
  logic [CW-1:0]    cnt;
  cmd_t             cur;
  cmd_t             head;
  logic [CMD_W-1:0] fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FCW-1:0]   fifo_count;
  logic             push;
  logic             pop;
  logic             hold;
  logic             align_ok;
  logic             can_start;
  logic             tick_first;
  logic             tick_last;
  logic             cyc_end;
  logic             cur_wr;
  logic             sample;
  logic [2:0]       smp_tick;

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = fifo_rdata;

  gb_seq_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .sys_clock (sys_clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .wdata     ({cmd_op, cmd_addr, cmd_data}),
    .rdata     (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef GB_SEQ_CART_CLK_EN
  localparam int DW = $clog2(4 * TICK_CYCLES);

  logic [DW-1:0] div;
  logic          phi;

  // PHI divider: half period is four ticks
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      div <= '0;
      phi <= 1'b0;
    end else if (div == DW'(4 * TICK_CYCLES - 1)) begin
      div <= '0;
      phi <= ~phi;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign cart_clk = phi;
  // start one clock early so T0 lands on the rise
  assign align_ok =
    (div == DW'(4 * TICK_CYCLES - 2)) && !phi;
`else
  assign cart_clk = 1'b0;
  assign align_ok = 1'b1;
`endif

  // an unconsumed response stalls the next read
  assign hold =
    is_read(head.op) && rsp_valid && !rsp_ready;
  assign can_start =
    !fifo_empty && !hold && align_ok;

  assign tick_first =
    (state == ST_CYCLE) && (cnt == '0);
  assign tick_last =
    (cnt == CW'(TICK_CYCLES - 1));
  assign cyc_end =
    (state == ST_CYCLE) && (tick == T_END) &&
    tick_last;
  assign pop =
    can_start &&
    ((state == ST_IDLE) || cyc_end);

  assign busy =
    (state == ST_CYCLE) || (fifo_count != '0);

  assign cur_wr = !is_read(cur.op);
  assign smp_tick =
    (cur.op == OP_RD_RAM) ?
      3'(RAM_SAMPLE_TICK) :
      3'(ROM_SAMPLE_TICK);
  assign sample =
    (state == ST_CYCLE) && tick_last &&
    is_read(cur.op) && (tick == smp_tick);

  // cycle FSM with tick and sub-tick counters
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      tick  <= '0;
      cnt   <= '0;
      cur   <= '0;
    end else if (pop) begin
      state <= ST_CYCLE;
      tick  <= '0;
      cnt   <= '0;
      cur   <= head;
    end else if (cyc_end) begin
      state <= ST_IDLE;
      tick  <= '0;
      cnt   <= '0;
    end else if (state == ST_CYCLE) begin
      if (tick_last) begin
        cnt  <= '0;
        tick <= tick + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // pin schedule, applied on the first clock of each tick
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      cart_a     <= IDLE_A;
      cart_d_out <= IDLE_D;
      cart_d_oe  <= IDLE_OE;
      cart_nCS   <= IDLE_NCS;
      cart_nRD   <= IDLE_NRD;
      cart_nWR   <= IDLE_NWR;
    end else if (cyc_end) begin
      cart_nRD  <= IDLE_NRD;
      cart_d_oe <= IDLE_OE;
      cart_nCS  <= IDLE_NCS;
    end else if (tick_first) begin
      unique case (1'b1)
        (tick == T_BEG): begin
          cart_nRD  <= IDLE_NRD;
          cart_nWR  <= IDLE_NWR;
          cart_nCS  <= IDLE_NCS;
          cart_d_oe <= IDLE_OE;
          if (cur.op == OP_RD_ROM) begin
            cart_a[15] <= 1'b1;
          end
        end
        (tick == T_ADDR): begin
          cart_a <= cur.addr;
          if (cur_wr) begin
            cart_d_oe <= 1'b1;
            cart_nRD  <= 1'b1;
          end
        end
        (tick == T_SEL): begin
          if (cur.op == OP_WR_REG) begin
            cart_a[15] <= 1'b0;
          end
          if (is_ram(cur.op)) begin
            cart_nCS <= 1'b0;
          end
        end
        (tick == T_WR): begin
          if (cur_wr) begin
            cart_nWR   <= 1'b0;
            cart_d_out <= cur.data;
          end
        end
        (tick == T_END): begin
          if (cur_wr) begin
            cart_nWR <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // read response register; a fresh sample wins over a consume
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
    end else if (sample) begin
      rsp_valid <= 1'b1;
      rsp_data  <= cart_d_in;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gb_cart_bus_sequencer.sv
// Directed bench for gb_cart_bus_sequencer.
// Define GB_SEQ_CART_CLK_EN to exercise the aligned PHI clock.
module tb_gb_cart_bus_sequencer;
  import gb_seq_pkg::*;

  localparam int TC  = 13;
  localparam int H   = 6;
  localparam int CYC = 8 * TC;

  logic        sys_clock = 1'b0;
  logic        reset     = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op    = 2'd0;
  logic [15:0] cmd_addr  = 16'h0;
  logic [7:0]  cmd_data  = 8'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_data;
  logic        busy;
  logic        cart_clk;
  logic [15:0] cart_a;
  logic [7:0]  cart_d_out;
  logic        cart_d_oe;
  logic [7:0]  cart_d_in = 8'h00;
  logic        cart_nCS;
  logic        cart_nRD;
  logic        cart_nWR;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  localparam logic [39:0] RST_VEC = {
    16'h0000, 8'h00, 1'b0, 1'b1, 1'b0,
    1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1
  };

  gb_cart_bus_sequencer #(
    .TICK_CYCLES     (TC),
    .FIFO_DEPTH      (4),
    .RAM_SAMPLE_TICK (5),
    .ROM_SAMPLE_TICK (4)
  ) dut (
    .sys_clock  (sys_clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .cart_clk   (cart_clk),
    .cart_a     (cart_a),
    .cart_d_out (cart_d_out),
    .cart_d_oe  (cart_d_oe),
    .cart_d_in  (cart_d_in),
    .cart_nCS   (cart_nCS),
    .cart_nRD   (cart_nRD),
    .cart_nWR   (cart_nWR)
  );

  always #5 sys_clock = ~sys_clock;

  always @(posedge sys_clock) cyc <= cyc + 1;

  function automatic logic [27:0] bus();
    return {cart_a, cart_d_out, cart_d_oe,
            cart_nCS, cart_nRD, cart_nWR};
  endfunction

  function automatic logic [39:0] all_pins();
    return {cart_a, cart_d_out, cart_d_oe,
            cart_nCS, cart_nRD, cart_nWR, cart_clk,
            rsp_valid, rsp_data, busy, cmd_ready};
  endfunction

  function automatic int tm(input int p, input int k);
    return p + 2 + k * TC + H;
  endfunction

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(posedge sys_clock);
      #1;
    end
  endtask

  task automatic push_cmd(
    input  logic [1:0]  op,
    input  logic [15:0] a,
    input  logic [7:0]  d,
    output int          acc
  );
    int n;
    n = 0;
    @(negedge sys_clock);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    while (!cmd_ready && n < 4 * CYC) begin
      @(negedge sys_clock);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL push_timeout: cmd_ready=%b want 1",
               cmd_ready);
    end
    tests++;
    @(posedge sys_clock);
    #1;
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge sys_clock);
    if (all_pins() !== RST_VEC) begin
      fails++;
      $display("FAIL reset_vals: got %h want %h",
               all_pins(), RST_VEC);
    end
    tests++;
    reset = 1'b0;
    repeat (5) @(negedge sys_clock);
    if (all_pins() !== RST_VEC) begin
      fails++;
      $display("FAIL post_reset_idle: got %h want %h",
               all_pins(), RST_VEC);
    end
    tests++;
  endtask

  task automatic test_wr_reg;
    int p;
    logic [27:0] e;
    push_cmd(OP_WR_REG, 16'h4000, 8'h10, p);
    wait_until(tm(p, 0));
    e = {16'h0000, 8'h00, 4'b0101};
    if (bus() !== e) begin
      fails++;
      $display("FAIL wr_reg_t0: got %h want %h", bus(), e);
    end
    tests++;
    wait_until(tm(p, 1));
    e = {16'h4000, 8'h00, 4'b1111};
    if (bus() !== e) begin
      fails++;
      $display("FAIL wr_reg_t1: got %h want %h", bus(), e);
    end
    tests++;
    wait_until(tm(p, 2));
    if (bus() !== e) begin
      fails++;
      $display("FAIL wr_reg_t2: got %h want %h", bus(), e);
    end
    tests++;
    wait_until(tm(p, 4));
    e = {16'h4000, 8'h10, 4'b1110};
    if (bus() !== e) begin
      fails++;
      $display("FAIL wr_reg_t4: got %h want %h", bus(), e);
    end
    tests++;
    wait_until(tm(p, 6));
    if (bus() !== e) begin
      fails++;
      $display("FAIL wr_reg_t6: got %h want %h", bus(), e);
    end
    tests++;
    wait_until(p + CYC);
    e = {16'h4000, 8'h10, 4'b1111};
    if (bus() !== e) begin
      fails++;
      $display("FAIL wr_reg_t7_last: got %h want %h",
               bus(), e);
    end
    tests++;
    wait_until(p + 1 + CYC);
    e = {16'h4000, 8'h10, 4'b0101};
    if ({bus(), busy} !== {e, 1'b0}) begin
      fails++;
      $display("FAIL wr_reg_end: got %h/%b want %h/0",
               bus(), busy, e);
    end
    tests++;
  endtask

  task automatic test_wr_ram;
    int p;
    logic [27:0] e;
    push_cmd(OP_WR_RAM, 16'hA001, 8'h80, p);
    wait_until(tm(p, 1));
    e = {16'hA001, 8'h10, 4'b1111};
    if (bus() !== e) begin
      fails++;
      $display("FAIL wr_ram_t1: got %h want %h", bus(), e);
    end
    tests++;
    wait_until(tm(p, 2));
    e = {16'hA001, 8'h10, 4'b1011};
    if (bus() !== e) begin
      fails++;
      $display("FAIL wr_ram_t2: got %h want %h", bus(), e);
    end
    tests++;
    wait_until(tm(p, 4));
    e = {16'hA001, 8'h80, 4'b1010};
    if (bus() !== e) begin
      fails++;
      $display("FAIL wr_ram_t4: got %h want %h", bus(), e);
    end
    tests++;
    wait_until(tm(p, 7));
    e = {16'hA001, 8'h80, 4'b1011};
    if (bus() !== e) begin
      fails++;
      $display("FAIL wr_ram_t7: got %h want %h", bus(), e);
    end
    tests++;
    wait_until(p + 1 + CYC);
    e = {16'hA001, 8'h80, 4'b0101};
    if (bus() !== e) begin
      fails++;
      $display("FAIL wr_ram_end: got %h want %h", bus(), e);
    end
    tests++;
  endtask

  task automatic test_reads;
    int p;
    int q;
    int r;
    logic [27:0] e;
    cart_d_in = 8'h5A;
    push_cmd(OP_RD_RAM, 16'hA000, 8'hFF, p);
    wait_until(tm(p, 2));
    e = {16'hA000, 8'h80, 4'b0001};
    if (bus() !== e) begin
      fails++;
      $display("FAIL rd_ram_t2: got %h want %h", bus(), e);
    end
    tests++;
    wait_until(tm(p, 5));
    if (rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rd_ram_early: rsp_valid=%b want 0",
               rsp_valid);
    end
    tests++;
    wait_until(tm(p, 6));
    cart_d_in = 8'h00;
    if ({rsp_valid, rsp_data} !== {1'b1, 8'h5A}) begin
      fails++;
      $display("FAIL rd_ram_rsp: got %b/%h want 1/5a",
               rsp_valid, rsp_data);
    end
    tests++;
    push_cmd(OP_RD_ROM, 16'h0100, 8'h00, q);
    wait_until(p + 1 + CYC + 20);
    e = {16'hA000, 8'h80, 4'b0101};
    if ({bus(), busy} !== {e, 1'b1}) begin
      fails++;
      $display("FAIL rd_rom_held: got %h/%b want %h/1",
               bus(), busy, e);
    end
    tests++;
    @(negedge sys_clock);
    rsp_ready = 1'b1;
    @(posedge sys_clock);
    #1;
    r = cyc;
    if (rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rsp_consume: rsp_valid=%b want 0",
               rsp_valid);
    end
    tests++;
    @(negedge sys_clock);
    rsp_ready = 1'b0;
    wait_until(tm(r - 1, 1));
    cart_d_in = 8'hC3;
    e = {16'h0100, 8'h80, 4'b0101};
    if (bus() !== e) begin
      fails++;
      $display("FAIL rd_rom_t1: got %h want %h", bus(), e);
    end
    tests++;
    wait_until(tm(r - 1, 4));
    if (rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rd_rom_early: rsp_valid=%b want 0",
               rsp_valid);
    end
    tests++;
    wait_until(tm(r - 1, 5));
    if ({rsp_valid, rsp_data} !== {1'b1, 8'hC3}) begin
      fails++;
      $display("FAIL rd_rom_rsp: got %b/%h want 1/c3",
               rsp_valid, rsp_data);
    end
    tests++;
    wait_until(r + CYC + 2);
    rsp_ready = 1'b1;
    wait_until(r + CYC + 4);
    if ({rsp_valid, busy} !== 2'b00) begin
      fails++;
      $display("FAIL rd_drain: valid/busy=%b%b want 00",
               rsp_valid, busy);
    end
    tests++;
  endtask

  task automatic test_back_to_back;
    int p;
    int a6;
    int d;
    push_cmd(OP_WR_RAM, 16'hA010, 8'h11, p);
    wait_until(tm(p, 1));
    if (cart_a !== 16'hA010) begin
      fails++;
      $display("FAIL b2b_c1_addr: got %h want a010", cart_a);
    end
    tests++;
    push_cmd(OP_WR_REG, 16'hA200, 8'h22, d);
    push_cmd(OP_RD_ROM, 16'h0100, 8'h33, d);
    push_cmd(OP_WR_REG, 16'h3000, 8'h44, d);
    push_cmd(OP_WR_RAM, 16'hA030, 8'h55, d);
    if ({cmd_ready, busy} !== 2'b01) begin
      fails++;
      $display("FAIL b2b_full: ready/busy=%b%b want 01",
               cmd_ready, busy);
    end
    tests++;
    push_cmd(OP_WR_REG, 16'h1234, 8'h66, a6);
    if (a6 !== p + 2 + CYC) begin
      fails++;
      $display("FAIL b2b_held_accept: got %0d want %0d",
               a6, p + 2 + CYC);
    end
    tests++;
    wait_until(tm(p + CYC, 1));
    if (cart_a !== 16'hA200) begin
      fails++;
      $display("FAIL b2b_c2_t1: got %h want a200", cart_a);
    end
    tests++;
    wait_until(tm(p + CYC, 2));
    if (cart_a !== 16'h2200) begin
      fails++;
      $display("FAIL b2b_c2_a15: got %h want 2200", cart_a);
    end
    tests++;
    wait_until(tm(p + 2 * CYC, 0));
    if (cart_a !== 16'hA200) begin
      fails++;
      $display("FAIL b2b_c3_rom_t0: got %h want a200",
               cart_a);
    end
    tests++;
    wait_until(tm(p + 2 * CYC, 1));
    if (cart_a !== 16'h0100) begin
      fails++;
      $display("FAIL b2b_c3_t1: got %h want 0100", cart_a);
    end
    tests++;
    wait_until(tm(p + 3 * CYC, 1));
    if (cart_a !== 16'h3000) begin
      fails++;
      $display("FAIL b2b_c4_t1: got %h want 3000", cart_a);
    end
    tests++;
    wait_until(tm(p + 4 * CYC, 4));
    if ({cart_a, cart_d_out} !== {16'hA030, 8'h55}) begin
      fails++;
      $display("FAIL b2b_c5_t4: got %h/%h want a030/55",
               cart_a, cart_d_out);
    end
    tests++;
    wait_until(tm(p + 5 * CYC, 1));
    if (cart_a !== 16'h1234) begin
      fails++;
      $display("FAIL b2b_c6_t1: got %h want 1234", cart_a);
    end
    tests++;
    wait_until(p + 6 * CYC);
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_busy_last: got %b want 1", busy);
    end
    tests++;
    wait_until(p + 1 + 6 * CYC);
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle: got %b want 0", busy);
    end
    tests++;
  endtask

  task automatic test_reset_mid;
    int p;
    int d;
    push_cmd(OP_WR_RAM, 16'hA001, 8'h80, p);
    push_cmd(OP_WR_REG, 16'h4000, 8'h10, d);
    push_cmd(OP_RD_ROM, 16'h0200, 8'h00, d);
    wait_until(tm(p, 4));
    if (cart_nWR !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_t4: nWR=%b want 0", cart_nWR);
    end
    tests++;
    reset = 1'b1;
    #1;
    if (all_pins() !== RST_VEC) begin
      fails++;
      $display("FAIL rst_mid_async: got %h want %h",
               all_pins(), RST_VEC);
    end
    tests++;
    @(posedge sys_clock);
    #1;
    if (all_pins() !== RST_VEC) begin
      fails++;
      $display("FAIL rst_mid_edge: got %h want %h",
               all_pins(), RST_VEC);
    end
    tests++;
    @(negedge sys_clock);
    reset = 1'b0;
    wait_until(cyc + 3 * TC);
    if (all_pins() !== RST_VEC) begin
      fails++;
      $display("FAIL rst_mid_flushed: got %h want %h",
               all_pins(), RST_VEC);
    end
    tests++;
  endtask

`ifdef GB_SEQ_CART_CLK_EN
  task automatic test_cart_clk;
    int r1;
    int r2;
    int p;
    logic prev;
    r1 = -1;
    r2 = -1;
    prev = cart_clk;
    for (int n = 0; n < 3 * CYC && r2 < 0; n++) begin
      @(posedge sys_clock);
      #1;
      if (cart_clk && !prev) begin
        if (r1 < 0) r1 = cyc;
        else r2 = cyc;
      end
      prev = cart_clk;
    end
    if (r2 - r1 !== CYC) begin
      fails++;
      $display("FAIL clk_period: got %0d want %0d",
               r2 - r1, CYC);
    end
    tests++;
    wait_until(r2 + 3 * TC);
    push_cmd(OP_WR_REG, 16'h4000, 8'h10, p);
    wait_until(r2 + CYC);
    if (cart_clk !== 1'b1) begin
      fails++;
      $display("FAIL clk_rise: cart_clk=%b want 1",
               cart_clk);
    end
    tests++;
    wait_until(r2 + CYC + TC - 1);
    if (cart_d_oe !== 1'b0) begin
      fails++;
      $display("FAIL clk_align_pre: oe=%b want 0",
               cart_d_oe);
    end
    tests++;
    wait_until(r2 + CYC + TC);
    if (cart_d_oe !== 1'b1) begin
      fails++;
      $display("FAIL clk_align_t1: oe=%b want 1",
               cart_d_oe);
    end
    tests++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded limit",
             $time);
    $fatal(1);
  end

  initial begin
    test_reset;
`ifdef GB_SEQ_CART_CLK_EN
    test_cart_clk;
`else
    test_wr_reg;
    test_wr_ram;
    test_reads;
    test_back_to_back;
    test_reset_mid;
`endif
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
